i2c_slave_regif: RTL and testbench
==================================

# i2c_slave_regif

I2C target (slave) that sits on the same two-wire bus as the in-house I2C master and bridges bus transactions onto a simple 8-bit register-access port. It oversamples SCL/SDA in the system clock domain, detects START/STOP, matches a 7-bit device address, takes a register pointer, and then performs auto-incrementing writes or reads. It serves as the FPGA-side endpoint for board-level control and as the loopback target for master verification.

## Interface
- `DEV_ADDR`, 7'h50: 7-bit device address this target responds to.
- `clk`  in  1: system clock; must be ≥10× SCL frequency.
- `reset`  in  1: synchronous, active-high reset.
- `scl`  in  1: bus SCL (asynchronous; never driven by this block).
- `sda_i`  in  1: bus SDA, sampled value from the pad buffer.
- `sda_oe`  out  1: 1 = pull SDA low; 0 = release. Open-drain only; the block never drives SDA high.
- `reg_addr`  out  8: current register pointer.
- `reg_wdata`  out  8: write data, valid while `reg_wr`=1.
- `reg_wr`  out  1: one-clk write strobe.
- `reg_rd`  out  1: one-clk read request for `reg_addr`.
- `reg_rdata`  in  8: read data; sampled exactly 2 clk after `reg_rd`.
- `busy`  out  1: high from address match until STOP, START, or reset.
- `start_det`  out  1: one-clk pulse on START or repeated START.
- `stop_det`  out  1: one-clk pulse on STOP.

## Operation
- Input conditioning: 2-flop synchronizer on `scl` and `sda_i`, followed by edge detection on the synchronized SCL.
- START: synchronized SDA falls while SCL=1. STOP: SDA rises while SCL=1. Both are honoured in every state.
  - START → ADDR, bit counter cleared.
  - STOP → IDLE, `sda_oe`=0.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Bits shift MSB-first on SCL rising edges. Eight bits complete a byte.
- ADDR: on the 8th bit, if byte[7:1]==DEV_ADDR:
  - go to ADDR_ACK, `busy`=1;
  - if R/W=1, pulse `reg_rd`.
  - On mismatch, go to IGNORE. IGNORE never drives SDA or strobes and waits for START or STOP.
- ACK drive: `sda_oe`=1 from the SCL fall after the 8th bit until the following SCL fall.
- ADDR_ACK exit: W → REG; R → RDATA.
- REG: byte loads `reg_addr`; ACK; then WDATA.
- WDATA: on each byte:
  - `reg_wdata`=byte, pulse `reg_wr` once at the 8th SCL rise;
  - ACK;
  - `reg_addr` increments after the strobe, 8-bit wrap 0xFF→0x00.
- RDATA:
  - The shift register loads `reg_rdata` 2 clk after `reg_rd`.
  - Each bit is driven on SCL fall: `sda_oe`=~bit.
  - After 8 bits, SDA is released for the master's ACK/NACK, which is sampled on SCL rise in RDATA_ACK.
  - ACK (SDA=0) → increment `reg_addr`, pulse `reg_rd`, continue in RDATA.
  - NACK → IGNORE.
- Repeated START in any state discards any partial byte; `reg_addr` is retained, so write-pointer-then-read works.
- Reset values: `sda_oe`=0, `reg_addr`=0x00, `reg_wdata`=0x00, `reg_wr`=0, `reg_rd`=0, `busy`=0, `start_det`=0, `stop_det`=0, state IDLE.
- Reset mid-transaction releases SDA on the next clk.

## Timing
- Bus-to-internal latency: 2 clk (sync). Edge and START/STOP detection add +1 clk; `start_det`/`stop_det` assert 3 clk after the pad change.
- `sda_oe` changes 1 clk after a detected SCL fall. This gives SDA hold ≥ sync latency after the pad falls.
- `reg_wr` asserts 1 clk after the detected 8th SCL rise. `reg_wdata` and `reg_addr` are stable that cycle.
- `reg_rd` asserts 1 clk after the detected 8th address SCL rise, or the detected ACK SCL rise. It always precedes the next SCL fall because clk ≥ 10× SCL.
- Minimum clk/SCL-high ratio: 6 (8 with the filter). Below this, behaviour is undefined.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined: a 3-sample majority filter follows the synchronizer on SCL and SDA.
  - Pulses ≤1 clk are rejected.
  - Detection latency is +2 clk; every timing figure above grows by 2.
- Undefined: synchronizer only, with no pulse rejection.

## Test plan
- Write: START, 0xA0, 0x12, 0xA5, STOP →
  - three ACKs (`sda_oe`=1 during ACK bits);
  - one `reg_wr` with `reg_addr`=0x12, `reg_wdata`=0xA5;
  - `reg_addr`=0x13 after; `stop_det` pulse.
- Read: START, 0xA0, 0x40, repeated START, 0xA1, `reg_rdata`=0x3C, master NACK, STOP →
  - SDA bits 0,0,1,1,1,1,0,0;
  - exactly one `reg_rd` with `reg_addr`=0x40.
- Address mismatch: START, 0xA2, 0x55, STOP → `sda_oe` never 1, no strobes, `busy`=0 throughout.
- Burst wrap: START, 0xA0, 0xFF, 0x11, 0x22, STOP → `reg_wr` with (0xFF, 0x11) then (0x00, 0x22).
- Reset mid-read: `reset` asserted while `sda_oe`=1 → `sda_oe`=0 and all outputs at reset values 1 clk later. The next START/0xA0 is ACKed normally.
- Filter enabled: 1-clk low glitch on SDA while SCL=1 in IDLE → no `start_det`. With the macro undefined → `start_det` pulses.

Source files
------------

// File: rtl/i2c_slave_regif.sv
// rtl/i2c_slave_regif.sv - I2C target bridging bus transactions onto an 8-bit register port (optional I2C_SLAVE_GLITCH_FILTER_EN)
module i2c_slave_regif #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    state_t     state, state_n;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_c, sda_c, scl_d, sda_d;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       ack_drv, ack_drv_n, rw, rw_n, rd_d1;
    logic       sda_oe_n, reg_wr_n, reg_rd_n, busy_n;
    logic [7:0] reg_addr_n, reg_wdata_n;
    logic       scl_rise, scl_fall, start_c, stop_c;
    logic [7:0] byte_in;

    // Synchronizers idle high so a reset never fabricates a START.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_f, sda_f;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_f    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_f    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end

    assign scl_c = scl_f;
    assign sda_c = sda_f;
`else
    assign scl_c = scl_sync[1];
    assign sda_c = sda_sync[1];
`endif

    assign scl_rise = scl_c & ~scl_d;
    assign scl_fall = ~scl_c & scl_d;
    assign start_c  = scl_c & scl_d & sda_d & ~sda_c;
    assign stop_c   = scl_c & scl_d & ~sda_d & sda_c;
    assign byte_in  = {shift[6:0], sda_c};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            ack_drv   <= 1'b0;
            rw        <= 1'b0;
            rd_d1     <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            state     <= state_n;
            scl_d     <= scl_c;
            sda_d     <= sda_c;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            ack_drv   <= ack_drv_n;
            rw        <= rw_n;
            rd_d1     <= reg_rd;
            sda_oe    <= sda_oe_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            reg_wr    <= reg_wr_n;
            reg_rd    <= reg_rd_n;
            busy      <= busy_n;
            start_det <= start_c;
            stop_det  <= stop_c;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        ack_drv_n   = ack_drv;
        rw_n        = rw;
        sda_oe_n    = sda_oe;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        reg_wr_n    = 1'b0;
        reg_rd_n    = 1'b0;
        busy_n      = busy;

        // Pointer advances the cycle after a write strobe; read data lands 2 clk after reg_rd.
        if (reg_wr)
            reg_addr_n = reg_addr + 8'd1;
        if (rd_d1)
            shift_n = reg_rdata;

        if (start_c) begin
            state_n   = S_ADDR;
            bit_cnt_n = 4'd0;
            ack_drv_n = 1'b0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_c) begin
            state_n  = S_IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_REG, S_WDATA: begin
                    if (scl_rise) begin
                        shift_n   = byte_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = 4'd0;
                            ack_drv_n = 1'b0;
                            if (state == S_ADDR) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state_n  = S_ADDR_ACK;
                                    busy_n   = 1'b1;
                                    rw_n     = byte_in[0];
                                    reg_rd_n = byte_in[0];
                                end else begin
                                    state_n = S_IGNORE;
                                end
                            end else if (state == S_REG) begin
                                reg_addr_n = byte_in;
                                state_n    = S_REG_ACK;
                            end else begin
                                reg_wdata_n = byte_in;
                                reg_wr_n    = 1'b1;
                                state_n     = S_WDATA_ACK;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                    // First fall starts the ACK, second fall ends it.
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_oe_n  = 1'b1;
                            ack_drv_n = 1'b1;
                        end else begin
                            ack_drv_n = 1'b0;
                            bit_cnt_n = 4'd0;
                            sda_oe_n  = 1'b0;
                            if (state == S_ADDR_ACK && rw) begin
                                state_n  = S_RDATA;
                                sda_oe_n = ~shift[7];
                            end else if (state == S_ADDR_ACK) begin
                                state_n = S_REG;
                            end else begin
                                state_n = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise)
                        bit_cnt_n = bit_cnt + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n  = 1'b0;
                            ack_drv_n = 1'b0;
                            state_n   = S_RDATA_ACK;
                        end else begin
                            shift_n  = {shift[6:0], 1'b0};
                            sda_oe_n = ~shift[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_c) begin
                            reg_addr_n = reg_addr + 8'd1;
                            reg_rd_n   = 1'b1;
                            ack_drv_n  = 1'b1;
                        end else begin
                            state_n = S_IGNORE;
                        end
                    end
                    if (scl_fall && ack_drv) begin
                        state_n   = S_RDATA;
                        bit_cnt_n = 4'd0;
                        ack_drv_n = 1'b0;
                        sda_oe_n  = ~shift[7];
                    end
                end
                S_IDLE, S_IGNORE: ;
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb/tb_i2c_slave_regif.sv - scoreboard bench for i2c_slave_regif
module tb_i2c_slave_regif;
    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_wr, reg_rd, busy, start_det, stop_det;

    int errors = 0;
    int checks = 0;

    logic [15:0] q_wr[$];
    logic [7:0]  q_rd[$];
    logic [1:0]  q_ev[$];
    logic [1:0]  q_bit[$];
    logic [1:0]  be;
    logic [15:0] we;
    logic [7:0]  re;
    logic [1:0]  ee;

    assign sda_i = sda_m & ~sda_oe;

    i2c_slave_regif #(.DEV_ADDR(7'h50)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda_i(sda_i), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .busy(busy), .start_det(start_det), .stop_det(stop_det)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bus bit monitor: samples sda_oe mid-SCL-high for every rising edge.
    always @(posedge scl) begin
        #(Q);
        if (q_bit.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bit_queue: unexpected SCL rise, no expectation queued");
        end else begin
            be = q_bit.pop_front();
            if (be[1])
                check("sda_oe_bit", 16'(sda_oe), 16'(be[0]));
        end
    end

    // Strobe and bus-condition monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wr) begin
                if (q_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL reg_wr: unexpected strobe addr=%h data=%h", reg_addr, reg_wdata);
                end else begin
                    we = q_wr.pop_front();
                    check("reg_wr_addr_data", {reg_addr, reg_wdata}, we);
                end
            end
            if (reg_rd) begin
                if (q_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL reg_rd: unexpected strobe addr=%h", reg_addr);
                end else begin
                    re = q_rd.pop_front();
                    check("reg_rd_addr", 16'(reg_addr), 16'(re));
                end
            end
            if (start_det || stop_det) begin
                if (q_ev.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_event: unexpected start=%b stop=%b", start_det, stop_det);
                end else begin
                    ee = q_ev.pop_front();
                    check("bus_event", 16'({start_det, stop_det}), 16'(ee));
                end
            end
        end
    end

    task automatic put_bit(input logic b, input logic chk, input logic exp_oe);
        sda_m = b;
        #(Q);
        q_bit.push_back({chk, exp_oe});
        scl = 1'b1;
        #(2 * Q);
        scl = 1'b0;
        #(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--)
            put_bit(d[i], 1'b1, 1'b0);
        put_bit(1'b1, 1'b1, ack);
    endtask

    task automatic rd_byte(input logic [7:0] d, input logic nack);
        for (int i = 7; i >= 0; i--)
            put_bit(1'b1, 1'b1, ~d[i]);
        put_bit(nack, 1'b1, 1'b0);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        #(Q);
        if (!scl) begin
            q_bit.push_back(2'b00);
            scl = 1'b1;
        end
        #(Q);
        q_ev.push_back(2'b10);
        sda_m = 1'b0;
        #(Q);
        scl = 1'b0;
        #(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        #(Q);
        q_bit.push_back(2'b00);
        scl = 1'b1;
        #(Q);
        q_ev.push_back(2'b01);
        sda_m = 1'b1;
        #(2 * Q);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda_oe"}, 16'(sda_oe), 16'h0);
        check({tag, "_reg_addr"}, 16'(reg_addr), 16'h0);
        check({tag, "_reg_wdata"}, 16'(reg_wdata), 16'h0);
        check({tag, "_strobes"}, 16'({reg_wr, reg_rd}), 16'h0);
        check({tag, "_busy"}, 16'(busy), 16'h0);
        check({tag, "_det"}, 16'({start_det, stop_det}), 16'h0);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        scl       = 1'b1;
        sda_m     = 1'b1;
        reg_rdata = 8'h00;
        repeat (4) @(negedge clk);
        check_reset_outputs("init");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Write 0xA5 to register 0x12
        bus_start();
        wr_byte(8'hA0, 1'b1);
        check("write_busy", 16'(busy), 16'h1);
        wr_byte(8'h12, 1'b1);
        q_wr.push_back(16'h12A5);
        wr_byte(8'hA5, 1'b1);
        bus_stop();
        check("write_ptr_after", 16'(reg_addr), 16'h13);
        check("write_busy_after", 16'(busy), 16'h0);

        // Pointer write then repeated-START read of 0x3C with NACK
        bus_start();
        wr_byte(8'hA0, 1'b1);
        wr_byte(8'h40, 1'b1);
        bus_start();
        reg_rdata = 8'h3C;
        q_rd.push_back(8'h40);
        wr_byte(8'hA1, 1'b1);
        rd_byte(8'h3C, 1'b1);
        bus_stop();
        check("read_ptr_after", 16'(reg_addr), 16'h40);

        // Address mismatch: no ACK, no strobes, never busy
        bus_start();
        wr_byte(8'hA2, 1'b0);
        check("mismatch_busy", 16'(busy), 16'h0);
        wr_byte(8'h55, 1'b0);
        bus_stop();
        check("mismatch_busy_after", 16'(busy), 16'h0);

        // Burst write wrapping 0xFF -> 0x00
        bus_start();
        wr_byte(8'hA0, 1'b1);
        wr_byte(8'hFF, 1'b1);
        q_wr.push_back(16'hFF11);
        wr_byte(8'h11, 1'b1);
        q_wr.push_back(16'h0022);
        wr_byte(8'h22, 1'b1);
        bus_stop();
        check("burst_ptr_after", 16'(reg_addr), 16'h01);

        // Reset while ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--)
            put_bit(1'(8'hA0 >> i), 1'b1, 1'b0);
        check("ack_before_reset", 16'(sda_oe), 16'h1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        bus_start();
        wr_byte(8'hA0, 1'b1);
        wr_byte(8'h05, 1'b1);
        bus_stop();
        check("post_reset_ptr", 16'(reg_addr), 16'h05);

        // 1-clk SDA low glitch while SCL high in IDLE
        @(negedge clk);
`ifndef I2C_SLAVE_GLITCH_FILTER_EN
        q_ev.push_back(2'b10);
        q_ev.push_back(2'b01);
`endif
        sda_m = 1'b0;
        @(negedge clk);
        sda_m = 1'b1;
        repeat (20) @(negedge clk);

        #(4 * Q);
        check("q_wr_drained", 16'(q_wr.size()), 16'h0);
        check("q_rd_drained", 16'(q_rd.size()), 16'h0);
        check("q_ev_drained", 16'(q_ev.size()), 16'h0);
        check("q_bit_drained", 16'(q_bit.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
